// File: rtl/dff_monitor.sv
// rtl/dff_monitor.sv - registered response checker for a single D flip-flop
//
// Parameters
//   CNT_W        width of err_count / chk_count (saturating)
//   STOP_ON_ERR  1: first error parks the monitor in HALT until reset
// Ports
//   clk          monitor clock, same clock as the observed flop
//   reset        asynchronous active-low monitor reset
//   dut_reset    observed flop's active-high reset
//   mon_d        observed flop d input
//   mon_q        observed flop q output (pre-edge value)
//   mon_qb       observed flop qb output (pre-edge value)
//   clear        synchronous clear of counters, fault and err_code
//   err_pulse    one-cycle flag: the last sampled edge had an error
//   err_code     0 none, 1 QB, 2 RESET_VALUE, 3 DATA; held until next error or clear
//   fault        sticky error flag
//   err_count    saturating count of error edges
//   chk_count    saturating count of checked edges
//   state        IDLE=0, IN_RST=1, PRIME=2, CHECK=3 (HALT also reads 3)

module dff_monitor #(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dut_reset,
    input  logic             mon_d,
    input  logic             mon_q,
    input  logic             mon_qb,
    input  logic             clear,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic             fault,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] chk_count,
    output logic [1:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IN_RST = 3'd1,
        S_PRIME  = 3'd2,
        S_CHECK  = 3'd3,
        S_HALT   = 3'd4
    } mon_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mon_state_t cur_state;
    mon_state_t nxt_state;
    logic       d_prev;
    logic       checking;
    logic       qb_bad;
    logic       rst_bad;
    logic       data_bad;
    logic       any_err;
    logic [1:0] code_now;

    always_comb begin
        nxt_state = cur_state;
        checking  = 1'b0;
        qb_bad    = 1'b0;
        rst_bad   = 1'b0;
        data_bad  = 1'b0;
        case (cur_state)
            S_IDLE: begin
                // an unreset flop has no defined value to check against
                if (dut_reset) nxt_state = S_IN_RST;
            end
            S_IN_RST, S_PRIME: begin
                // PRIME still expects the reset value: d_prev is not yet valid
                checking  = 1'b1;
                qb_bad    = (mon_qb == mon_q);
                rst_bad   = mon_q;
                if (dut_reset)
                    nxt_state = S_IN_RST;
                else if (cur_state == S_IN_RST)
                    nxt_state = S_PRIME;
                else
                    nxt_state = S_CHECK;
            end
            S_CHECK: begin
                checking = 1'b1;
                qb_bad   = (mon_qb == mon_q);
                // a reset seen mid-CHECK is judged by reset rules on the same edge
                if (dut_reset) begin
                    rst_bad   = mon_q;
                    nxt_state = S_IN_RST;
                end else begin
                    data_bad  = (mon_q != d_prev);
                end
            end
            S_HALT: begin
                nxt_state = S_HALT;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase

        any_err = qb_bad | rst_bad | data_bad;

        if (qb_bad)
            code_now = 2'd1;
        else if (rst_bad)
            code_now = 2'd2;
        else if (data_bad)
            code_now = 2'd3;
        else
            code_now = 2'd0;

        if (any_err && STOP_ON_ERR) nxt_state = S_HALT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_IDLE;
            d_prev    <= 1'b0;
            err_pulse <= 1'b0;
            err_code  <= 2'd0;
            fault     <= 1'b0;
            err_count <= '0;
            chk_count <= '0;
        end else begin
            cur_state <= nxt_state;
            // history is rebuilt every edge; PRIME guarantees it is fresh before CHECK uses it
            d_prev    <= mon_d;
            if (clear) begin
                err_pulse <= 1'b0;
                err_code  <= 2'd0;
                fault     <= 1'b0;
                err_count <= '0;
                chk_count <= '0;
            end else begin
                err_pulse <= any_err;
                if (any_err) begin
                    err_code <= code_now;
                    fault    <= 1'b1;
                    if (err_count != '1) err_count <= err_count + CNT_ONE;
                end
                if (checking && (chk_count != '1)) chk_count <= chk_count + CNT_ONE;
            end
        end
    end

    assign state = (cur_state == S_HALT) ? 2'd3 : cur_state[1:0];

endmodule

// File: tb/tb_dff_monitor.sv
// tb/tb_dff_monitor.sv - directed scoreboard bench for dff_monitor

module tb_dff_monitor;

    logic clk;
    logic resetn;
    logic dut_reset;
    logic mon_d;
    logic mon_q;
    logic mon_qb;
    logic clear;

    logic       pulse_b, pulse_s, pulse_h;
    logic [1:0] code_b, code_s, code_h;
    logic       fault_b, fault_s, fault_h;
    logic [7:0] ec_b, ec_h;
    logic [7:0] cc_b, cc_h;
    logic [2:0] ec_s, cc_s;
    logic [1:0] st_b, st_s, st_h;

    int tests = 0;
    int fails = 0;
    int step_no = 0;

    typedef struct {
        int         sel;
        int         id;
        logic       pulse;
        logic [1:0] code;
        logic       fault;
        int         ec;
        int         cc;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];

    dff_monitor u_base (
        .clk(clk), .reset(resetn), .dut_reset(dut_reset), .mon_d(mon_d),
        .mon_q(mon_q), .mon_qb(mon_qb), .clear(clear),
        .err_pulse(pulse_b), .err_code(code_b), .fault(fault_b),
        .err_count(ec_b), .chk_count(cc_b), .state(st_b)
    );

    dff_monitor #(.CNT_W(3)) u_sat (
        .clk(clk), .reset(resetn), .dut_reset(dut_reset), .mon_d(mon_d),
        .mon_q(mon_q), .mon_qb(mon_qb), .clear(clear),
        .err_pulse(pulse_s), .err_code(code_s), .fault(fault_s),
        .err_count(ec_s), .chk_count(cc_s), .state(st_s)
    );

    dff_monitor #(.STOP_ON_ERR(1'b1)) u_halt (
        .clk(clk), .reset(resetn), .dut_reset(dut_reset), .mon_d(mon_d),
        .mon_q(mon_q), .mon_qb(mon_qb), .clear(clear),
        .err_pulse(pulse_h), .err_code(code_h), .fault(fault_h),
        .err_count(ec_h), .chk_count(cc_h), .state(st_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s step %0d: observed %0d required %0d", tag, id, obs, exp);
        end
    endtask

    task automatic push_exp(input int sel, input logic ep, input logic [1:0] ecode, input logic ef,
                            input int eerr, input int echk, input logic [1:0] est);
        exp_t e;
        e.sel   = sel;
        e.id    = step_no;
        e.pulse = ep;
        e.code  = ecode;
        e.fault = ef;
        e.ec    = eerr;
        e.cc    = echk;
        e.st    = est;
        sb.push_back(e);
        step_no++;
    endtask

    task automatic compare_head();
        exp_t e;
        logic [31:0] o_pulse, o_code, o_fault, o_ec, o_cc, o_st;
        if (sb.size() == 0) begin
            check("scoreboard_empty", step_no, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        case (e.sel)
            1: begin
                o_pulse = 32'(pulse_s); o_code = 32'(code_s); o_fault = 32'(fault_s);
                o_ec = 32'(ec_s); o_cc = 32'(cc_s); o_st = 32'(st_s);
            end
            2: begin
                o_pulse = 32'(pulse_h); o_code = 32'(code_h); o_fault = 32'(fault_h);
                o_ec = 32'(ec_h); o_cc = 32'(cc_h); o_st = 32'(st_h);
            end
            default: begin
                o_pulse = 32'(pulse_b); o_code = 32'(code_b); o_fault = 32'(fault_b);
                o_ec = 32'(ec_b); o_cc = 32'(cc_b); o_st = 32'(st_b);
            end
        endcase
        check("err_pulse", e.id, o_pulse, 32'(e.pulse));
        check("err_code",  e.id, o_code,  32'(e.code));
        check("fault",     e.id, o_fault, 32'(e.fault));
        check("err_count", e.id, o_ec,    32'(e.ec));
        check("chk_count", e.id, o_cc,    32'(e.cc));
        check("state",     e.id, o_st,    32'(e.st));
    endtask

    // drive one edge worth of stimulus, queue what must come out, compare after the edge
    task automatic step(input logic dr, input logic d, input logic q, input logic qb, input logic clr,
                        input int sel, input logic ep, input logic [1:0] ecode, input logic ef,
                        input int eerr, input int echk, input logic [1:0] est);
        push_exp(sel, ep, ecode, ef, eerr, echk, est);
        dut_reset = dr;
        mon_d     = d;
        mon_q     = q;
        mon_qb    = qb;
        clear     = clr;
        @(posedge clk);
        #1;
        compare_head();
    endtask

    task automatic reset_step(input int sel);
        resetn = 1'b0;
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'b0, sel, 1'b0, 2'd0, 1'b0, 0, 0, 2'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        dut_reset = 1'b1;
        mon_d     = 1'b0;
        mon_q     = 1'b0;
        mon_qb    = 1'b1;
        clear     = 1'b0;

        // reset held: everything quiet whatever the flop does
        for (int i = 0; i < 4; i++) reset_step(0);
        resetn = 1'b1;

        // correct flop: reset twice, deassert with d=0, then d = 1,0,1,1
        step(1, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd1);
        step(1, 0, 0, 1, 0, 0, 0, 2'd0, 0, 0, 1, 2'd1);
        step(0, 0, 0, 1, 0, 0, 0, 2'd0, 0, 0, 2, 2'd2);
        step(0, 1, 0, 1, 0, 0, 0, 2'd0, 0, 0, 3, 2'd3);
        step(0, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 4, 2'd3);
        step(0, 1, 0, 1, 0, 0, 0, 2'd0, 0, 0, 5, 2'd3);
        step(0, 1, 1, 0, 0, 0, 0, 2'd0, 0, 0, 6, 2'd3);
        step(0, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 7, 2'd3);

        // data error with d_prev=1, then a correct edge
        step(0, 1, 0, 1, 0, 0, 0, 2'd0, 0, 0, 8, 2'd3);
        step(0, 1, 0, 1, 0, 0, 1, 2'd3, 1, 1, 9, 2'd3);
        step(0, 0, 1, 0, 0, 0, 0, 2'd3, 1, 1, 10, 2'd3);

        // QB and DATA together: QB wins, one count
        step(0, 1, 0, 1, 0, 0, 0, 2'd3, 1, 1, 11, 2'd3);
        step(0, 0, 0, 0, 0, 0, 1, 2'd1, 1, 2, 12, 2'd3);

        // reset mid-CHECK with a clean reset value, then RESET_VALUE error in IN_RST
        step(1, 0, 0, 1, 0, 0, 0, 2'd1, 1, 2, 13, 2'd1);
        step(1, 0, 1, 0, 0, 0, 1, 2'd2, 1, 3, 14, 2'd1);

        // clear on an erroring edge wins; state is kept
        step(1, 0, 1, 1, 1, 0, 0, 2'd0, 0, 0, 0, 2'd1);
        step(1, 0, 0, 1, 0, 0, 0, 2'd0, 0, 0, 1, 2'd1);

        // saturation with 3-bit counters
        reset_step(1);
        resetn = 1'b1;
        step(1, 0, 0, 1, 0, 1, 0, 2'd0, 0, 0, 0, 2'd1);
        for (int k = 1; k <= 10; k++)
            step(1, 0, 1, 0, 0, 1, 1, 2'd2, 1, (k < 7) ? k : 7, (k < 7) ? k : 7, 2'd1);
        step(1, 0, 1, 0, 1, 1, 0, 2'd0, 0, 0, 0, 2'd1);
        step(1, 0, 1, 0, 0, 1, 1, 2'd2, 1, 1, 1, 2'd1);

        // HALT on first DATA error
        reset_step(2);
        resetn = 1'b1;
        step(1, 0, 0, 1, 0, 2, 0, 2'd0, 0, 0, 0, 2'd1);
        step(0, 1, 0, 1, 0, 2, 0, 2'd0, 0, 0, 1, 2'd2);
        step(0, 1, 0, 1, 0, 2, 0, 2'd0, 0, 0, 2, 2'd3);
        step(0, 0, 0, 1, 0, 2, 1, 2'd3, 1, 1, 3, 2'd3);
        step(0, 1, 1, 1, 0, 2, 0, 2'd3, 1, 1, 3, 2'd3);
        step(1, 0, 1, 0, 0, 2, 0, 2'd3, 1, 1, 3, 2'd3);
        step(0, 0, 0, 0, 0, 2, 0, 2'd3, 1, 1, 3, 2'd3);

        // asynchronous reset between edges clears everything at once
        #3;
        resetn = 1'b0;
        push_exp(2, 0, 2'd0, 0, 0, 0, 2'd0);
        #1;
        compare_head();
        resetn = 1'b1;
        step(0, 0, 0, 1, 0, 2, 0, 2'd0, 0, 0, 0, 2'd0);

        check("scoreboard_drained", step_no, 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
